// File: rtl/dec7seg_scan.sv
// Time-multiplexed 7-segment driver: captures a packed digit word, scans DIGITS
// anodes from one shared segment bus, with blanking, leading-zero suppression and polarity select.
module dec7seg_scan #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int HEX        = 0,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  RST_L,
    input  logic [4*DIGITS-1:0]   codes,
    input  logic [DIGITS-1:0]     dps,
    input  logic                  load,
    input  logic                  BL_L,
    input  logic                  LZ_L,
    output logic [0:6]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic             POL      = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [4*DIGITS-1:0] codes_q, codes_d;
    logic [DIGITS-1:0]   dps_q,   dps_d;
    logic [0:6]          seg_q,   seg_d;
    logic                dp_q,    dp_d;
    logic [DIGITS-1:0]   an_q,    an_d;
    logic                frame_q, frame_d;

    logic                wrap;
    logic [3:0]          cur_code;
    logic                cur_dp;
    logic                cur_supp;
    logic [DIGITS-1:0]   lz_mask;
    logic [DIGITS-1:0]   an_l;
    logic [0:6]          seg_l;
    logic                dp_l;
    logic                lead;

    function automatic logic [0:6] decode(input logic [3:0] c);
        logic [0:6] s;
        case (c)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1110011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        if (HEX == 0 && c > 4'h9) begin
            s = 7'b0000000;
        end
        return s;
    endfunction

    // Scan timing and shadow capture
    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        frame_d = wrap && (idx_q == IDX_LAST);
        codes_d = load ? codes : codes_q;
        dps_d   = load ? dps : dps_q;
    end

    // A digit is suppressible when it and every more-significant digit are zero
    always_comb begin
        lead    = 1'b1;
        lz_mask = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead       = lead && (codes_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lead;
        end
    end

    always_comb begin
        cur_code = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        an_l     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code = codes_q[4*i +: 4];
                cur_dp   = dps_q[i];
                cur_supp = lz_mask[i];
                an_l[i]  = 1'b1;
            end
        end
    end

    // Output decode; blanking overrides everything, polarity applied last
    always_comb begin
        seg_l = decode(cur_code);
        dp_l  = cur_dp;
        if (!LZ_L && cur_supp) begin
            seg_l = 7'b0000000;
        end
        if (!BL_L) begin
            seg_l = 7'b0000000;
            dp_l  = 1'b0;
        end
        seg_d = seg_l ^ {7{POL}};
        dp_d  = dp_l ^ POL;
        an_d  = (BL_L ? an_l : '0) ^ {DIGITS{POL}};
    end

    always_ff @(posedge clk) begin
        if (!RST_L) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            codes_q <= '0;
            dps_q   <= '0;
            seg_q   <= {7{POL}};
            dp_q    <= POL;
            an_q    <= {DIGITS{POL}};
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            codes_q <= codes_d;
            dps_q   <= dps_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dp    = dp_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
